// File: rtl/ball_cfg_if.sv
// Velocity configuration channel for the ball motion sequencer.
// The master offers a write with cfg_valid; the sequencer answers with cfg_ready.
interface ball_cfg_if;
  logic       cfg_valid;
  logic [2:0] cfg_idx;
  logic [8:0] cfg_vx;
  logic [8:0] cfg_vy;
  logic       cfg_ready;

  modport master (output cfg_valid, output cfg_idx, output cfg_vx, output cfg_vy, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_idx, input cfg_vx, input cfg_vy, output cfg_ready);
endinterface

// File: rtl/ball_motion_sequencer.sv
// Per-frame ball position update with edge bounce, plus registered per-ball pixel hit.
// state  | meaning
// IDLE   | waiting for frame_tick; accepts velocity writes
// MOVE   | add velocity to position of ball idx into temporaries
// BOUNCE | clamp/reflect and write back ball idx
// DONE   | pass complete, frame_done pulse
module ball_motion_sequencer #(
  parameter int NBALLS    = 4,
  parameter int BALL_SIZE = 4,
  parameter int XLIM      = 256,
  parameter int YLIM      = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              display_on,
  ball_cfg_if.slave         cfg,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [NBALLS-1:0] ball_gfx
);

  localparam int IW = (NBALLS > 1) ? $clog2(NBALLS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBALLS - 1);
  localparam logic [8:0] X_HIT   = 9'(XLIM - BALL_SIZE);
  localparam logic [8:0] X_CLAMP = 9'(XLIM - BALL_SIZE - 1);
  localparam logic [8:0] Y_HIT   = 9'(YLIM - BALL_SIZE);
  localparam logic [8:0] Y_CLAMP = 9'(YLIM - BALL_SIZE - 1);
  localparam logic [8:0] SIZE    = 9'(BALL_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_BOUNCE, S_DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic [8:0]    x [NBALLS];
  logic [8:0]    y [NBALLS];
  logic [8:0]    vx [NBALLS];
  logic [8:0]    vy [NBALLS];
  logic [8:0]    nx, ny;
  logic          cfg_we, bounce_we, cfg_in_range;
  logic [8:0]    cur_vx, cur_vy, bx, by, bvx, bvy;
  logic          hit_x, hit_y;

  assign cfg_in_range = ({1'b0, cfg.cfg_idx} < 4'(NBALLS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    cfg_we        = 1'b0;
    bounce_we     = 1'b0;
    busy          = (state != S_IDLE);
    frame_done    = (state == S_DONE);
    cfg.cfg_ready = (state == S_IDLE) && !frame_tick;
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          state_next = S_MOVE;
          idx_next   = '0;
        end else if (cfg.cfg_valid && cfg_in_range) begin
          cfg_we = 1'b1;
        end
      end
      S_MOVE:   state_next = S_BOUNCE;
      S_BOUNCE: begin
        bounce_we = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx + 1'b1;
          state_next = S_MOVE;
        end
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Clamp side depends on the direction of travel before reflection.
  always_comb begin
    cur_vx = vx[idx];
    cur_vy = vy[idx];
    hit_x  = (nx >= X_HIT);
    hit_y  = (ny >= Y_HIT);
    bvx    = hit_x ? (9'd0 - cur_vx) : cur_vx;
    bvy    = hit_y ? (9'd0 - cur_vy) : cur_vy;
    bx     = hit_x ? (cur_vx[8] ? 9'd0 : X_CLAMP) : nx;
    by     = hit_y ? (cur_vy[8] ? 9'd0 : Y_CLAMP) : ny;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nx <= '0;
      ny <= '0;
    end else if (state == S_MOVE) begin
      nx <= x[idx] + vx[idx];
      ny <= y[idx] + vy[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (frame_tick && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBALLS; i++) begin
        x[i]  <= 9'(64 + 32 * i);
        y[i]  <= 9'(64 + 16 * i);
        vx[i] <= (i % 2 == 0) ? 9'd2 : 9'd510;
        vy[i] <= 9'(i + 1);
      end
    end else begin
      for (int i = 0; i < NBALLS; i++) begin
        if (bounce_we && (idx == IW'(i))) begin
          x[i]  <= bx;
          y[i]  <= by;
          vx[i] <= bvx;
          vy[i] <= bvy;
        end else if (cfg_we && (cfg.cfg_idx == 3'(i))) begin
          vx[i] <= cfg.cfg_vx;
          vy[i] <= cfg.cfg_vy;
        end
      end
    end
  end

  // Offsets wrap modulo 512, so a beam left of / above the ball never hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_gfx <= '0;
    end else begin
      for (int i = 0; i < NBALLS; i++) begin
        ball_gfx[i] <= display_on && (9'(hpos - x[i]) < SIZE) && (9'(vpos - y[i]) < SIZE);
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Scoreboard bench: stimulus queues expected pass results and pixel probes, monitors check them.
module tb_ball_motion_sequencer;
  logic       clk = 1'b0;
  logic       reset, frame_tick, display_on;
  logic [8:0] hpos, vpos;
  logic       busy, frame_done, overrun;
  logic [3:0] ball_gfx;

  ball_cfg_if cfg_bus ();

  ball_motion_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .cfg(cfg_bus), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .ball_gfx(ball_gfx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int len; logic ovr; } pass_t;
  typedef struct { int ball; logic exp; int h; int v; } probe_t;
  pass_t  pass_q[$];
  probe_t probe_q[$];
  logic   probe_flag = 1'b0;
  logic   probe_d = 1'b0;
  int     busy_run = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) probe_d <= probe_flag;

  always @(negedge clk) begin : gfx_monitor
    probe_t p;
    if (probe_d) begin
      if (probe_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL gfx_unexpected: got probe result expected none");
      end else begin
        p = probe_q.pop_front();
        check($sformatf("gfx%0d@(%0d,%0d)", p.ball, p.h, p.v), int'(ball_gfx[p.ball]), int'(p.exp));
      end
    end
  end

  always @(negedge clk) begin : pass_monitor
    pass_t e;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      else busy_run = 0;
      if (frame_done) begin
        if (pass_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pass_unexpected: got frame_done expected none");
        end else begin
          e = pass_q.pop_front();
          check("pass_busy_len", busy_run, e.len);
          check("overrun_at_done", int'(overrun), int'(e.ovr));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 40 cycles");
    end
  endtask

  task automatic do_tick(input logic ovr_exp);
    @(negedge clk);
    frame_tick = 1'b1;
    pass_q.push_back('{9, ovr_exp});
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle();
  endtask

  task automatic cfg_write(input int i, input int vx, input int vy);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idx   = 3'(i);
    cfg_bus.cfg_vx    = 9'(vx);
    cfg_bus.cfg_vy    = 9'(vy);
    #1 check("cfg_ready_idle", int'(cfg_bus.cfg_ready), 1);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic probe(input int h, input int v, input logic d, input int ball, input logic exp);
    @(negedge clk);
    hpos = 9'(h);
    vpos = 9'(v);
    display_on = d;
    probe_q.push_back('{ball, exp, h, v});
    probe_flag = 1'b1;
    @(posedge clk);
    #1 probe_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; display_on = 1'b0; hpos = '0; vpos = '0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_idx = '0; cfg_bus.cfg_vx = '0; cfg_bus.cfg_vy = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(frame_done), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_gfx", int'(ball_gfx), 0);
    reset = 1'b0;
    #1 check("cfg_ready_after_reset", int'(cfg_bus.cfg_ready), 1);

    // first pass from reset positions
    do_tick(1'b0);
    probe(66, 65, 1'b1, 0, 1'b1);
    probe(65, 65, 1'b1, 0, 1'b0);
    probe(70, 65, 1'b1, 0, 1'b0);
    probe(69, 68, 1'b1, 0, 1'b1);
    probe(94, 82, 1'b1, 1, 1'b1);
    probe(93, 82, 1'b1, 1, 1'b0);
    probe(94, 81, 1'b1, 1, 1'b0);
    probe(94, 82, 1'b0, 1, 1'b0);

    // right-edge bounce
    cfg_write(0, 184, 0);
    do_tick(1'b0);
    probe(250, 65, 1'b1, 0, 1'b1);
    probe(249, 65, 1'b1, 0, 1'b0);
    cfg_write(0, 4, 0);
    do_tick(1'b0);
    probe(251, 65, 1'b1, 0, 1'b1);
    probe(250, 65, 1'b1, 0, 1'b0);
    do_tick(1'b0);
    probe(247, 65, 1'b1, 0, 1'b1);
    probe(246, 65, 1'b1, 0, 1'b0);
    probe(251, 65, 1'b1, 0, 1'b0);

    // top-edge bounce with zero horizontal velocity
    cfg_write(0, 0, 448);
    do_tick(1'b0);
    probe(247, 1, 1'b1, 0, 1'b1);
    probe(247, 0, 1'b1, 0, 1'b0);
    cfg_write(0, 0, 509);
    do_tick(1'b0);
    probe(247, 0, 1'b1, 0, 1'b1);
    probe(247, 4, 1'b1, 0, 1'b0);
    probe(247, 511, 1'b1, 0, 1'b0);
    do_tick(1'b0);
    probe(247, 3, 1'b1, 0, 1'b1);
    probe(247, 2, 1'b1, 0, 1'b0);

    // corner: both axes flip in one pass
    cfg_write(0, 6, 234);
    do_tick(1'b0);
    probe(251, 235, 1'b1, 0, 1'b1);
    probe(250, 235, 1'b1, 0, 1'b0);
    probe(251, 234, 1'b1, 0, 1'b0);
    do_tick(1'b0);
    probe(245, 1, 1'b1, 0, 1'b1);
    probe(244, 1, 1'b1, 0, 1'b0);
    probe(245, 0, 1'b1, 0, 1'b0);

    // overrun: second tick during the pass
    @(negedge clk);
    frame_tick = 1'b1;
    pass_q.push_back('{9, 1'b1});
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle();
    check("overrun_sticky", int'(overrun), 1);
    do_tick(1'b1);
    probe(233, 234, 1'b1, 0, 1'b1);
    probe(232, 234, 1'b1, 0, 1'b0);

    // cfg_valid held through a pass is not accepted
    @(negedge clk);
    frame_tick = 1'b1;
    pass_q.push_back('{9, 1'b1});
    @(negedge clk);
    frame_tick = 1'b0;
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_idx = 3'd0; cfg_bus.cfg_vx = 9'd0; cfg_bus.cfg_vy = 9'd0;
    #1 check("cfg_ready_busy", int'(cfg_bus.cfg_ready), 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("cfg_ready_busy", int'(cfg_bus.cfg_ready), 0);
    end
    @(negedge clk);
    check("cfg_ready_done", int'(cfg_bus.cfg_ready), 0);
    cfg_bus.cfg_valid = 1'b0;
    wait_idle();
    do_tick(1'b1);
    probe(221, 1, 1'b1, 0, 1'b1);
    probe(220, 1, 1'b1, 0, 1'b0);

    // cfg_valid coincident with tick is dropped
    @(negedge clk);
    frame_tick = 1'b1;
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_idx = 3'd0; cfg_bus.cfg_vx = 9'd0; cfg_bus.cfg_vy = 9'd0;
    pass_q.push_back('{9, 1'b1});
    #1 check("cfg_ready_tick", int'(cfg_bus.cfg_ready), 0);
    @(negedge clk);
    frame_tick = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    wait_idle();
    probe(215, 0, 1'b1, 0, 1'b1);
    do_tick(1'b1);
    probe(209, 234, 1'b1, 0, 1'b1);
    probe(208, 234, 1'b1, 0, 1'b0);

    // reset in the middle of a pass
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midpass_reset_busy", int'(busy), 0);
    check("midpass_reset_done", int'(frame_done), 0);
    check("midpass_reset_overrun", int'(overrun), 0);
    check("midpass_reset_gfx", int'(ball_gfx), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("cfg_ready_after_reset2", int'(cfg_bus.cfg_ready), 1);
    probe(64, 64, 1'b1, 0, 1'b1);
    probe(63, 64, 1'b1, 0, 1'b0);

    // beam sweep over ball0 at (100,100)
    cfg_write(0, 36, 36);
    do_tick(1'b0);
    for (int v = 98; v <= 105; v++) begin
      for (int h = 98; h <= 105; h++) begin
        probe(h, v, 1'b1, 0, (h >= 100 && h <= 103 && v >= 100 && v <= 103));
      end
    end
    probe(100, 100, 1'b0, 0, 1'b0);
    probe(103, 103, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("pass_queue_empty", pass_q.size(), 0);
    check("probe_queue_empty", probe_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_motion_sequencer.md
BALL_MOTION_SEQUENCER -- requirements
Module: ball_motion_sequencer

Interface
REQ-001 Parameter NBALLS, default 4; number of balls held in the register file, range 1..8.
REQ-002 Parameter BALL_SIZE, default 4; ball edge length in pixels.
REQ-003 Parameter XLIM, default 256; horizontal boundary in pixels.
REQ-004 Parameter YLIM, default 240; vertical boundary in pixels.
REQ-005 clk  in  1  pixel clock; the only clock; all state SHALL be clocked by it on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse marking start of vertical blank.
REQ-008 hpos, vpos  in  9 each  current beam position.
REQ-009 display_on  in  1  beam in visible area.
REQ-010 cfg_valid  in  1  velocity-write request.
REQ-011 cfg_idx  in  3  target ball index.
REQ-012 cfg_vx, cfg_vy  in  9 each  two's-complement velocities.
REQ-013 cfg_ready  out  1  sequencer can accept a configuration write.
REQ-014 busy  out  1  motion update in progress.
REQ-015 frame_done  out  1  one-cycle pulse when an update pass completes.
REQ-016 overrun  out  1  sticky flag: frame_tick arrived while busy.
REQ-017 ball_gfx  out  NBALLS  per-ball pixel hit, gated by display_on.

Function
REQ-018 State: per ball i, x[i], y[i], vx[i], vy[i], each 9 bits; FSM states IDLE, MOVE, BOUNCE, DONE.
REQ-019 IDLE + frame_tick -> MOVE, idx=0, busy=1 from next cycle.
REQ-020 MOVE (1 cycle): nx = x[idx]+vx[idx], ny = y[idx]+vy[idx], 9-bit modulo-512, latched in temporaries -> BOUNCE.
REQ-021 Horizontal bounce: if nx >= XLIM-BALL_SIZE, then vx[idx] = -vx[idx] (9-bit two's complement), and x[idx] = XLIM-BALL_SIZE-1 when vx[idx] bit8 was 0, or x[idx] = 0 when bit8 was 1; else x[idx] = nx.
REQ-022 Vertical bounce: identical to REQ-021 using ny, vy, YLIM.
REQ-023 Simultaneous horizontal and vertical hit: both handled in the same BOUNCE cycle.
REQ-024 BOUNCE writes x, y, vx, vy for idx; if idx == NBALLS-1 -> DONE, else idx+1 and -> MOVE.
REQ-025 DONE (1 cycle): frame_done=1, busy=0 next cycle, -> IDLE; whole pass takes 2*NBALLS+1 cycles after tick.
REQ-026 frame_tick while not IDLE: ignored for motion; overrun set to 1, cleared only by reset.
REQ-027 cfg_ready = 1 exactly when state is IDLE and frame_tick is 0.
REQ-028 cfg_valid & cfg_ready: vx[cfg_idx]=cfg_vx, vy[cfg_idx]=cfg_vy next edge; positions unchanged; cfg_idx >= NBALLS ignored.
REQ-029 cfg_valid & frame_tick in the same IDLE cycle: tick wins, write dropped (cfg_ready=0).
REQ-030 ball_gfx[i] = display_on & ((hpos-x[i]) mod 512 < BALL_SIZE) & ((vpos-y[i]) mod 512 < BALL_SIZE), registered one cycle.
REQ-031 Velocity 0 on an axis: position held; bounce still clamps if already at/over the limit.

Reset
REQ-032 Reset assertion SHALL immediately force FSM=IDLE, idx=0, busy=0, frame_done=0, overrun=0, ball_gfx=0.
REQ-033 Reset values: x[i]=64+32*i, y[i]=64+16*i, vx[i]=+2 (i even) or -2 = 510 (i odd), vy[i]=i+1.
REQ-034 Reset mid-pass SHALL abandon the pass; no partial-state retention; first post-reset tick starts from idx 0.
REQ-035 Reset deassertion: cfg_ready=1 on the first cycle the state is IDLE with no tick.

Verification
REQ-036 Reset, one frame_tick, NBALLS=4 -> busy high 9 cycles, frame_done pulse at cycle 9; ball0 (66,65), ball1 (94,82).
REQ-037 Write ball0 x=250, vx=+4, then tick -> x0=251, vx0=-4 (508); next tick -> x0=247.
REQ-038 Ball at y=1, vy=-3 (509), then tick -> y=0, vy=+3; corner case x=253, y=237 -> both axes flip in one pass.
REQ-039 frame_tick reasserted at cycle 3 of a pass -> pass completes normally in 9 cycles, overrun=1 and stays 1 until reset.
REQ-040 cfg_valid held during a pass -> cfg_ready=0, no velocity change; cfg_valid coincident with tick -> write dropped.
REQ-041 Ball0 at (100,100), beam swept over it with display_on=1 -> ball_gfx[0] high exactly for hpos 100..103 and vpos 100..103, one cycle late; with display_on=0 -> 0.
